// File: rtl/rca_word_sequencer.sv
// Sequences a wide add/subtract through one shared external 4-bit ripple-carry slice,
// one nibble per cycle, LSB first, with the carry held in a register between slices.
module rca_word_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   carry_out,
  output logic                   overflow,
  output logic [3:0]             rca_a,
  output logic [3:0]             rca_b,
  output logic                   rca_cin,
  input  logic [3:0]             rca_s,
  input  logic                   rca_cout
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    bm_q, bm_d;
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_out_q, carry_out_d;
  logic            overflow_q, overflow_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      bm_q        <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      bm_q        <= bm_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    bm_d        = bm_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = op_a;
          // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
          bm_d    = sub ? ~op_b : op_b;
          carry_d = sub;
          idx_d   = '0;
        end
      end
      StRun: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IdxW'(i)) sum_d[4*i +: 4] = rca_s;
        end
        carry_d = rca_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d     = StDone;
          carry_out_d = rca_cout;
          // The final slice sum carries the result MSB; sum_q is not yet updated.
          overflow_d  = (a_q[W-1] == bm_q[W-1]) && (rca_s[3] != a_q[W-1]);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    rca_a   = 4'h0;
    rca_b   = 4'h0;
    rca_cin = 1'b0;
    if (state_q == StRun) begin
      rca_cin = carry_q;
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IdxW'(i)) begin
          rca_a = a_q[4*i +: 4];
          rca_b = bm_q[4*i +: 4];
        end
      end
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Directed bench for rca_word_sequencer; the external 4-bit slice is modelled here
// as a plain combinational adder.
module tb_rca_word_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;
  logic [3:0]  rca_a;
  logic [3:0]  rca_b;
  logic        rca_cin;
  logic [3:0]  rca_s;
  logic        rca_cout;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [3:0]  cin_seq;

  rca_word_sequencer #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .rca_a     (rca_a),
    .rca_b     (rca_b),
    .rca_cin   (rca_cin),
    .rca_s     (rca_s),
    .rca_cout  (rca_cout)
  );

  assign {rca_cout, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {4'b0000, rca_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation from IDLE and checks latency, pulse shape and result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] exp_sum, input logic exp_c,
                        input logic exp_v);
    int k;
    bit seen;
    @(negedge clk);
    check({tag, "_idle_before"}, {30'd0, busy, done}, 32'd0);
    start = 1'b1;
    sub   = s;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 16'hDEAD;
    op_b  = 16'hBEEF;
    sub   = ~s;
    cin_seq = 4'h0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
      else if (k <= 4) cin_seq[k-1] = rca_cin;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, k, 32'd5);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_sum"}, {16'd0, sum}, {16'd0, exp_sum});
      check({tag, "_cv"}, {30'd0, carry_out, overflow}, {30'd0, exp_c, exp_v});
      check({tag, "_slice_idle"}, {23'd0, rca_a, rca_b, rca_cin}, 32'd0);
    end
  endtask

  initial begin
    int dones;
    logic [15:0] sum_at_done;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {29'd0, busy, done, carry_out}, 32'd0);
    check("reset_sum", {15'd0, overflow, sum}, 32'd0);
    check("reset_slice", {23'd0, rca_a, rca_b, rca_cin}, 32'd0);
    rst_n = 1'b1;

    // Back-to-back operations: each starts in the IDLE cycle right after DONE.
    run_op("add", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    check("add_cin_seq", {28'd0, cin_seq}, 32'h0000000E);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Second start at E2 lands while busy and must be dropped.
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b0;
    op_a  = 16'h1111;
    op_b  = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'h0F0F;
    op_b  = 16'h0F0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    sum_at_done = 16'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        sum_at_done = sum;
      end
    end
    check("reject_done_count", dones, 32'd1);
    check("reject_sum", {16'd0, sum_at_done}, 32'h00003333);
    check("reject_hold", {16'd0, sum}, 32'h00003333);

    // Asynchronous reset in the second RUN cycle, away from any clock edge.
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'h00FF;
    op_b  = 16'h00FF;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    check("midrst_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {30'd0, busy, done}, 32'd0);
    check("midrst_sum", {16'd0, sum}, 32'd0);
    check("midrst_slice", {23'd0, rca_a, rca_b, rca_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("midrst_no_done", dones, 32'd0);
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Idle interface stays quiet with no start.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", {21'd0, rca_a, rca_b, rca_cin, busy, done}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
